// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Radix-4 steps needed once operands are extended to width+2 bits.
  function automatic int booth_iter(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: multiplier bit triplet {q[2i+1], q[2i], q[2i-1]} to digit.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  // Standard radix-4 Booth table; 000 and 111 contribute nothing.
  always_comb begin
    digit = ZERO;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier with valid/ready on both sides.
// One recoded digit is retired per CALC cycle; {acc, q} shifts right by two
// each step so that after ITER steps it holds the exact extended product.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicando,
  input  logic [WIDTH-1:0]   multiplicador,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] resultado,
  output logic               busy
);

  localparam int ITER = booth_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);
  localparam int QW   = WIDTH + 2;  // extended operand width
  localparam int AW   = WIDTH + 4;  // accumulator width, wide enough for +-2M

  localparam logic [CW-1:0] CNT_INIT = CW'(ITER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [QW-1:0]      mcand_q, mcand_d;
  logic [QW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  booth_digit_t       digit;
  logic [AW-1:0]      m_ext, addend, sum;
  logic [AW+QW-1:0]   shifted;

  booth_r4_recoder u_rec (
    .triplet ({q_q[1], q_q[0], qm1_q}),
    .digit   (digit)
  );

  // One Booth step: add the selected multiple, then arithmetic shift {acc,q} by 2.
  always_comb begin
    m_ext  = {{2{mcand_q[QW-1]}}, mcand_q};
    addend = '0;
    case (digit)
      POS1:    addend = m_ext;
      POS2:    addend = {m_ext[AW-2:0], 1'b0};
      NEG1:    addend = -m_ext;
      NEG2:    addend = -{m_ext[AW-2:0], 1'b0};
      default: addend = '0;
    endcase
    sum     = acc_q + addend;
    shifted = $signed({sum, q_q}) >>> 2;
  end

  // FSM next-state, operand capture and result register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Sign or zero extension folds the mode into the operands, so
          // unsigned operations run through the same signed datapath.
          mcand_d = is_signed ? {{2{multiplicando[WIDTH-1]}}, multiplicando}
                              : {2'b00, multiplicando};
          q_d     = is_signed ? {{2{multiplicador[WIDTH-1]}}, multiplicador}
                              : {2'b00, multiplicador};
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = shifted[AW+QW-1:QW];
        q_d   = shifted[QW-1:0];
        qm1_d = q_q[1];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = shifted[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        // Leave via IDLE so a waiting operation is taken next cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign resultado = res_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Bench for booth_mult_r4: WIDTH=8 and WIDTH=16 instances, table vectors,
// random operations against an arithmetic model, and handshake corner cases.
module tb_booth_mult_r4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel16 = 1'b0;
  logic        iv = 1'b0;
  logic        sg = 1'b0;
  logic        ordy = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        ir8, ov8, bz8, ir16, ov16, bz16;
  logic [15:0] r8;
  logic [31:0] r16;
  logic        ir, ov, bz;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv & ~sel16), .in_ready(ir8),
    .is_signed(sg), .multiplicando(a[7:0]), .multiplicador(b[7:0]),
    .out_valid(ov8), .out_ready(ordy), .resultado(r8), .busy(bz8)
  );

  booth_mult_r4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv & sel16), .in_ready(ir16),
    .is_signed(sg), .multiplicando(a), .multiplicador(b),
    .out_valid(ov16), .out_ready(ordy), .resultado(r16), .busy(bz16)
  );

  assign ir  = sel16 ? ir16 : ir8;
  assign ov  = sel16 ? ov16 : ov8;
  assign bz  = sel16 ? bz16 : bz8;
  assign res = sel16 ? r16 : {16'h0, r8};

  typedef struct {
    bit          w16;
    bit          s;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*WIDTH bits.
  function automatic logic [31:0] ref_mul(input bit w16, input bit s,
                                          input logic [15:0] x, input logic [15:0] y);
    longint px, py, p;
    logic [7:0] x8, y8;
    x8 = x[7:0];
    y8 = y[7:0];
    if (w16) begin
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
    end else begin
      px = s ? longint'($signed(x8)) : longint'(x8);
      py = s ? longint'($signed(y8)) : longint'(y8);
    end
    p = px * py;
    return w16 ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  // Issue one operation, check latency, busy and result, then drain it.
  task automatic run(input bit w16, input bit s, input logic [15:0] x,
                     input logic [15:0] y, input logic [31:0] exp, input string nm);
    int t;
    int lat;
    sel16 = w16; sg = s; a = x; b = y;
    t = 0;
    while (!ir && t < 40) begin @(posedge clk); #1; t++; end
    chk({nm, "_ready"}, {31'h0, ir}, 32'h1);
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    a = ~x; b = ~y; sg = !s;   // must be ignored while busy
    lat = 0;
    while (!ov && lat < 40) begin
      chk({nm, "_busy"}, {31'h0, bz}, 32'h1);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, w16 ? 32'd9 : 32'd5);
    chk({nm, "_res"}, res, exp);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk({nm, "_idle"}, {30'h0, ir, ov}, 32'h2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] x, y;
    bit          w, s;
    int          e, n, r1, r2;
    logic [31:0] v1, v2;
    logic        prev;

    tbl[0] = '{1'b0, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000};
    tbl[1] = '{1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01};
    tbl[2] = '{1'b0, 1'b1, 16'h00FF, 16'h00FF, 32'h0000_0001};
    tbl[3] = '{1'b0, 1'b1, 16'h0007, 16'h00FD, 32'h0000_FFEB};
    tbl[4] = '{1'b0, 1'b0, 16'h0003, 16'h0004, 32'h0000_000C};
    tbl[5] = '{1'b0, 1'b1, 16'h007F, 16'h0080, 32'h0000_C080};
    tbl[6] = '{1'b0, 1'b0, 16'h0080, 16'h00FF, 32'h0000_7F80};
    tbl[7] = '{1'b0, 1'b1, 16'h0000, 16'h007F, 32'h0000_0000};
    tbl[8] = '{1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000};
    tbl[9] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};

    // Reset state
    #12;
    chk("rst_in_ready", {31'h0, ir8}, 32'h1);
    chk("rst_out_valid", {30'h0, ov8, ov16}, 32'h0);
    chk("rst_busy", {30'h0, bz8, bz16}, 32'h0);
    chk("rst_res8", {16'h0, r8}, 32'h0);
    chk("rst_res16", r16, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run(tbl[i].w16, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = 16'($urandom);
      run(w, s, x, y, ref_mul(w, s, x, y), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held while out_ready is low, inputs ignored.
    sel16 = 1'b0; sg = 1'b1; a = 16'h0007; b = 16'h00FD;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    e = 0;
    while (!ov8 && e < 40) begin @(posedge clk); #1; e++; end
    chk("bp_lat", e, 32'd5);
    for (int i = 0; i < 10; i++) begin
      iv = (i % 2 == 0);
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_hold", {13'h0, ov8, ir8, bz8, r8}, {13'h0, 3'b101, 16'hFFEB});
    end
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("bp_release", {13'h0, ov8, ir8, bz8, r8}, {13'h0, 3'b010, 16'hFFEB});

    // Back-to-back with in_valid and out_ready held high.
    sg = 1'b0; a = 16'd3; b = 16'd4; iv = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    a = 16'd5; b = 16'd6;
    e = 0; n = 0; r1 = -1; r2 = -1; v1 = '0; v2 = '0; prev = ov8;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      e++;
      if (ov8 && !prev) begin
        if (n == 0) begin r1 = e; v1 = {16'h0, r8}; end
        else begin r2 = e; v2 = {16'h0, r8}; end
        n++;
      end
      prev = ov8;
      if (e == 7) iv = 1'b0;
    end
    ordy = 1'b0;
    chk("b2b_first_lat", r1, 32'd5);
    chk("b2b_first_res", v1, 32'h000C);
    chk("b2b_second_at", r2, 32'd12);
    chk("b2b_second_res", v2, 32'h001E);
    chk("b2b_idle", {31'h0, ir8}, 32'h1);

    // Reset during the second CALC step aborts the operation.
    sg = 1'b0; a = 16'd100; b = 16'd100; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("rstmid_state", {13'h0, ov8, ir8, bz8, r8}, {13'h0, 3'b010, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid_hold", {31'h0, ov8}, 32'h0);
    end
    @(negedge clk) rst = 1'b1;
    run(1'b0, 1'b1, 16'h0007, 16'h00FD, 32'h0000_FFEB, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_r4.md
Name: booth_mult_r4

Overview:
- Parametrised radix-4 Booth sequential multiplier; next generation of the 8-bit radix-2 Booth multiplier used in the datapath.
- Configurable operand width, selectable signed/unsigned mode per operation, and full valid/ready handshake on both input and output sides (backpressure supported).
- Roughly halves iteration count versus radix-2.
- Sits between operand source (register file / test harness) and result consumer.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- ITER (localparam), (WIDTH+2)/2, radix-4 iterations per operation (5 for WIDTH=8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
- multiplicando  input  WIDTH  multiplicand.
- multiplicador  input  WIDTH  multiplier.
- out_valid  output  1  resultado holds a completed product.
- out_ready  input  1  consumer accepts resultado.
- resultado  output  2*WIDTH  product; signed or unsigned per latched mode.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, in_ready=1, out_valid=0, busy=0, resultado=0, counter=0, internal accumulator/operand registers cleared. Release is synchronous to clk.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands and is_signed, load counter=ITER, go to CALC.
  - CALC: one radix-4 step per cycle, counter decrements. When counter reaches 1 and the step completes, go to DONE.
  - DONE: out_valid=1, resultado stable. On out_ready, go to IDLE.
- Latency: accept at edge t0. out_valid is high after edge t0+ITER. Throughput is one operation per ITER+2 cycles with out_ready held high.
- in_ready=0 in CALC and DONE. in_valid and operand changes while busy are ignored. Operands are sampled only at the accept edge.
- Extension:
  - Operands are extended to WIDTH+2 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - Unsigned mode therefore uses the same ITER as signed.
- Recoding:
  - Step i uses triplet {q[2i+1], q[2i], q[2i-1]} with q[-1]=0.
  - Digit is one of 0, +M, +2M, -M, -2M.
  - Accumulator is WIDTH+4 bits (no overflow). Arithmetic right shift by 2 after each add.
- resultado is the low 2*WIDTH bits of the exact product. Always exact for both modes; no saturation.
- resultado is updated only on entry to DONE. It holds its value after the output handshake until the next completion.
- out_valid is asserted in the same cycle as resultado is updated. It never drops before out_ready.
- Simultaneous events:
  - out_ready in DONE together with in_valid: the new operation is NOT accepted that cycle. It is accepted in the following IDLE cycle.
  - out_ready outside DONE has no effect.
- Reset mid-operation aborts: no out_valid pulse, resultado=0.

Decomposition:
- Shared package booth_pkg:
  - state_t enum {IDLE, CALC, DONE}.
  - booth_digit_t enum {ZERO, POS1, POS2, NEG1, NEG2}.
  - Function booth_iter(width) returning (width+2)/2.
- One combinational sub-module, booth_r4_recoder: 3-bit triplet in, booth_digit_t out.
- FSM, counter, accumulator and output register stay in booth_mult_r4.

Test Plan:
- WIDTH=8, is_signed=1, -128 x -128 (0x80, 0x80) -> resultado=0x4000, out_valid exactly 5 cycles after accept, busy high throughout.
- WIDTH=8, operands 0xFF x 0xFF: is_signed=0 -> 0xFE01; is_signed=1 -> 0x0001; same latency in both modes.
- Backpressure: 7 x -3 completes, out_ready held low 10 cycles -> resultado=0xFFEB stable, out_valid=1, in_ready=0, in_valid pulses with other operands ignored; out_ready high -> IDLE next cycle.
- Back-to-back with out_ready=1 and in_valid=1 continuously: 3x4 then 5x6 -> 0x000C then 0x001E, second accept one cycle after first DONE handshake, period ITER+2=7 cycles.
- Reset mid-CALC: assert rst low during step 2 of 100x100 -> out_valid=0, resultado=0, in_ready=1 immediately. After release, 7 x -3 -> 0xFFEB with normal latency.
- WIDTH=16, is_signed=1, -32768 x 32767 -> resultado=0xC0008000, out_valid 9 cycles after accept.
